// File: rtl/slon5_pkg.sv
// slon5_pkg: shared display constants and types for the slon5 board blocks.
package slon5_pkg;
    localparam int SEG_W = 8;
    localparam int DIG_N = 4;
    typedef logic [SEG_W-1:0] Seg_t;
    typedef Seg_t Dout_t;
    typedef logic [DIG_N-1:0] Dnum_t;
    typedef enum logic [1:0] {IDLE, GRANT, GUARD} ArbState_t;
endpackage

// File: rtl/slon5_scan_tmr.sv
// slon5_scan_tmr: free-running digit scan divider, digit index and frame tick.
module slon5_scan_tmr #(
    parameter int SCAN_DIV = 1000,
    parameter int DIG_N = 4,
    localparam int VW = $clog2(SCAN_DIV),
    localparam int DW = DIG_N > 1 ? $clog2(DIG_N) : 1
) (
    input  logic          clk,
    input  logic          rst,
    output logic [DW-1:0] dig,
    output logic          frame_tick
);
    logic [VW-1:0] div;
    logic wrap;
    assign wrap = div == VW'(SCAN_DIV - 1);
    assign frame_tick = wrap && dig == DW'(DIG_N - 1);
    always_ff @(posedge clk) begin
        if (!rst) begin
            div <= '0;
            dig <= '0;
        end else begin
            div <= wrap ? '0 : div + 1'b1;
            if (wrap) dig <= dig == DW'(DIG_N - 1) ? '0 : dig + 1'b1;
        end
    end
endmodule

// File: rtl/slon5_disp_arb.sv
// slon5_disp_arb: round-robin, frame-aligned sharing of the slon5 digit display.
// Define SLON5_DISP_ARB_PRIO_EN to make requester 0 urgent.
module slon5_disp_arb
    import slon5_pkg::*;
#(
    parameter int REQ_N = 4,
    parameter int DIG_N = 4,
    parameter int SCAN_DIV = 1000,
    parameter int HOLD_FRAMES = 16,
    localparam int PW = $clog2(REQ_N),
    localparam int DW = DIG_N > 1 ? $clog2(DIG_N) : 1,
    localparam int FW = $clog2(HOLD_FRAMES + 1)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [REQ_N-1:0]             req,
    input  logic [REQ_N*DIG_N*SEG_W-1:0] seg,
    output logic [REQ_N-1:0]             gnt,
    output logic                         busy,
    output logic [SEG_W-1:0]             dout,
    output logic [DIG_N-1:0]             dnum
);
    logic [DW-1:0] dig;
    logic frame_tick;
    ArbState_t state, state_nx;
    logic [PW-1:0] owner, owner_nx, rr_ptr, rr_nx, pick, off, owner_inc;
    logic [PW:0] pick_sum;
    logic [FW-1:0] frames, frames_nx;
    logic [REQ_N-1:0] gnt_nx;
    logic [2*REQ_N-1:0] rot;
    logic busy_nx, others, rel, show;
    Seg_t seg_a [REQ_N][DIG_N];
    Seg_t seg_sel;

    slon5_scan_tmr #(.SCAN_DIV(SCAN_DIV), .DIG_N(DIG_N)) u_tmr (
        .clk(clk),
        .rst(rst),
        .dig(dig),
        .frame_tick(frame_tick)
    );

    for (genvar r = 0; r < REQ_N; r++) begin : g_r
        for (genvar d = 0; d < DIG_N; d++) begin : g_d
            assign seg_a[r][d] = seg[(r*DIG_N+d)*SEG_W +: SEG_W];
        end
    end
    assign seg_sel = seg_a[owner][dig];

    // Rotate req so rr_ptr sits at bit 0; the lowest set bit is the round-robin winner.
    assign rot = {req, req} >> rr_ptr;
    always_comb begin
        off = '0;
        for (int i = REQ_N - 1; i >= 0; i--)
            if (rot[i]) off = PW'(i);
    end
    assign pick_sum = {1'b0, rr_ptr} + {1'b0, off};
    always_comb begin
        pick = pick_sum >= (PW+1)'(REQ_N) ? PW'(pick_sum - (PW+1)'(REQ_N)) : PW'(pick_sum);
`ifdef SLON5_DISP_ARB_PRIO_EN
        if (req[0]) pick = '0;
`endif
    end

    assign owner_inc = owner == PW'(REQ_N - 1) ? '0 : owner + 1'b1;
    assign others = |(req & ~(REQ_N'(1) << owner));
`ifdef SLON5_DISP_ARB_PRIO_EN
    assign rel = !req[owner] || (frames >= FW'(HOLD_FRAMES - 1) && others) || (owner != '0 && req[0]);
`else
    assign rel = !req[owner] || (frames >= FW'(HOLD_FRAMES - 1) && others);
`endif

    always_comb begin
        state_nx = state;
        owner_nx = owner;
        rr_nx = rr_ptr;
        frames_nx = frames;
        gnt_nx = gnt;
        busy_nx = busy;
        if (frame_tick) begin
            case (state)
                IDLE: if (|req) begin
                    state_nx = GRANT;
                    owner_nx = pick;
                    frames_nx = '0;
                    gnt_nx = REQ_N'(1) << pick;
                    busy_nx = 1'b1;
                end
                GRANT: begin
                    frames_nx = frames == FW'(HOLD_FRAMES) ? frames : frames + 1'b1;
                    if (rel) begin
                        state_nx = GUARD;
                        gnt_nx = '0;
                        busy_nx = 1'b0;
`ifdef SLON5_DISP_ARB_PRIO_EN
                        rr_nx = owner == '0 ? rr_ptr : owner_inc;
`else
                        rr_nx = owner_inc;
`endif
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    // Blank on the release edge too, so the display never outlives the grant.
    assign show = state == GRANT && state_nx == GRANT;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            owner <= '0;
            rr_ptr <= '0;
            frames <= '0;
            gnt <= '0;
            busy <= 1'b0;
            dout <= '0;
            dnum <= '0;
        end else begin
            state <= state_nx;
            owner <= owner_nx;
            rr_ptr <= rr_nx;
            frames <= frames_nx;
            gnt <= gnt_nx;
            busy <= busy_nx;
            dout <= show ? seg_sel : '0;
            dnum <= show ? DIG_N'(1) << dig : '0;
        end
    end
endmodule

// File: tb/tb_slon5_disp_arb.sv
// tb_slon5_disp_arb: random and directed stimulus checked against a frame-level model.
module tb_slon5_disp_arb;
    localparam int REQ_N = 4, DIG_N = 4, SCAN_DIV = 4, HOLD_FRAMES = 2, SEG_W = 8;
    localparam int FRAME = SCAN_DIV * DIG_N;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [REQ_N-1:0] req = '0;
    logic [REQ_N*DIG_N*SEG_W-1:0] seg = '0;
    logic [REQ_N-1:0] gnt;
    logic busy;
    logic [SEG_W-1:0] dout;
    logic [DIG_N-1:0] dnum;

    int n_vec = 0, n_err = 0;
    int m_n = 0, m_own = -1, m_wait = 0, m_rr = 0, m_held = 0;
    logic [REQ_N-1:0] e_gnt;
    logic e_busy;
    logic [SEG_W-1:0] e_dout;
    logic [DIG_N-1:0] e_dnum;

    always #5 clk = ~clk;

    slon5_disp_arb #(.REQ_N(REQ_N), .DIG_N(DIG_N), .SCAN_DIV(SCAN_DIV), .HOLD_FRAMES(HOLD_FRAMES)) dut (
        .clk(clk), .rst(rst), .req(req), .seg(seg),
        .gnt(gnt), .busy(busy), .dout(dout), .dnum(dnum)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // Frame-level view: who owns the display, and how many ticks remain blank.
    task automatic frame_tick_model();
        logic others, rel;
        if (m_own < 0) begin
            if (m_wait > 0) m_wait--;
            else if (req != 0) begin
                for (int k = 0; k < REQ_N; k++)
                    if (m_own < 0 && req[(m_rr + k) % REQ_N]) m_own = (m_rr + k) % REQ_N;
`ifdef SLON5_DISP_ARB_PRIO_EN
                if (req[0]) m_own = 0;
`endif
                m_held = 0;
            end
        end else begin
            others = (req & ~(REQ_N'(1) << m_own)) != 0;
            rel = !req[m_own] || (m_held >= HOLD_FRAMES - 1 && others);
`ifdef SLON5_DISP_ARB_PRIO_EN
            rel = rel || (m_own != 0 && req[0]);
            if (rel && m_own != 0) m_rr = (m_own + 1) % REQ_N;
`else
            if (rel) m_rr = (m_own + 1) % REQ_N;
`endif
            if (rel) begin
                m_own = -1;
                m_wait = 1;
            end else m_held++;
        end
    endtask

    task automatic model_step();
        int own_before, dg;
        if (!rst) begin
            m_n = 0; m_own = -1; m_wait = 0; m_rr = 0; m_held = 0;
            e_gnt = '0; e_busy = 1'b0; e_dout = '0; e_dnum = '0;
            return;
        end
        own_before = m_own;
        dg = (m_n / SCAN_DIV) % DIG_N;
        if (m_n % FRAME == FRAME - 1) frame_tick_model();
        m_n++;
        e_gnt = m_own >= 0 ? REQ_N'(1) << m_own : '0;
        e_busy = m_own >= 0;
        if (own_before >= 0 && m_own >= 0) begin
            e_dnum = DIG_N'(1) << dg;
            e_dout = seg[(m_own*DIG_N + dg)*SEG_W +: SEG_W];
        end else begin
            e_dnum = '0;
            e_dout = '0;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check("gnt", 32'(gnt), 32'(e_gnt));
        check("busy", 32'(busy), 32'(e_busy));
        check("dnum", 32'(dnum), 32'(e_dnum));
        check("dout", 32'(dout), 32'(e_dout));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic pulse_reset();
        rst = 1'b0;
        cycle();
        rst = 1'b1;
    endtask

    initial begin
        int t;
        seg = {$urandom, $urandom, $urandom, $urandom};
        run(5);
        seg[32 +: 32] = 32'h11223344;
        req = 4'b0010;
        rst = 1'b1;
        t = 0;
        while (gnt == '0 && t < 100) begin
            cycle();
            t++;
        end
        check("first_gnt_latency", 32'(t), 32'(FRAME));
        run(10 * FRAME);
        check("single_hold_gnt", 32'(gnt), 32'b0010);

        req = 4'b0011;
        pulse_reset();
        run(10 * FRAME);

        req = 4'b0100;
        pulse_reset();
        run(2 * FRAME + 6);
        req = 4'b1001;
        run(6 * FRAME);

        req = 4'b1100;
        pulse_reset();
        run(2 * FRAME + 3);
        pulse_reset();
        run(4 * FRAME);

        req = 4'b1000;
        pulse_reset();
        run(FRAME + 2);
        req = 4'b1001;
        run(6 * FRAME);

        for (int i = 0; i < 5000; i++) begin
            if ($urandom_range(0, 29) == 0) req = REQ_N'($urandom);
            if ($urandom_range(0, 3) == 0) seg[$urandom_range(0, REQ_N*DIG_N-1)*SEG_W +: SEG_W] = SEG_W'($urandom);
            rst = $urandom_range(0, 699) != 0;
            cycle();
        end
        rst = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
